// File: rtl/tdm_pkg.sv
// Definitions shared by the transmit-side TDM mux and the receive-side demux.
package tdm_pkg;

    localparam int TDM_N_CH_DEFAULT = 4;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-N_CH slot counter: synchronous clear, load-to-1 and increment-on-enable.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH_DEFAULT,
    localparam int SW = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] slot
);

    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    // Explicit wrap compare so non-power-of-2 frame lengths work.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SW'(1);
        end else if (inc) begin
            if (slot == LAST) slot <= '0;
            else              slot <= slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Framed TDM demultiplexer: aligns to sync, steers slot bits into a shadow
// frame and publishes each complete frame on out with a one-cycle valid.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_HUNT   | no alignment; waiting for an enabled cycle with sync=1
// ST_LOCKED | aligned; each enabled cycle carries the bit for `slot`
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH_DEFAULT,
    localparam int SW = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in,
    input  logic            sync,
    input  logic            enable,
    output logic [N_CH-1:0] out,
    output logic            valid,
    output logic            locked,
    output logic            sync_err,
    output logic [SW-1:0]   slot
);

    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    tdm_state_e      state, state_d;
    logic [N_CH-1:0] shadow, shadow_d;
    logic            valid_d, sync_err_d;
    logic            cnt_load1, cnt_inc;

    tdm_slot_counter #(.N_CH(N_CH)) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_HUNT;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_HUNT:   if (enable && sync) state_d = ST_LOCKED;
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        shadow_d   = shadow;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;
        if (enable) begin
            case (state)
                ST_HUNT: begin
                    if (sync) begin
                        shadow_d    = '0;
                        shadow_d[0] = in;
                        cnt_load1   = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sync && slot != '0) begin
                        // Misaligned marker: drop the partial frame and restart at slot 0.
                        sync_err_d  = 1'b1;
                        shadow_d    = '0;
                        shadow_d[0] = in;
                        cnt_load1   = 1'b1;
                    end else begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (slot == SW'(k)) shadow_d[k] = in;
                        end
                        cnt_inc = 1'b1;
                        valid_d = (slot == LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            out      <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            shadow   <= shadow_d;
            valid    <= valid_d;
            sync_err <= sync_err_d;
            if (valid_d) out <= shadow_d;
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (N_CH=4): directed scenarios plus a random soak, all
// compared every cycle against a frame-level queue model.
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int SW   = $clog2(N_CH);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in = 1'b0;
    logic            sync = 1'b0;
    logic            enable = 1'b0;
    logic [N_CH-1:0] out;
    logic            valid;
    logic            locked;
    logic            sync_err;
    logic [SW-1:0]   slot;

    tdm_demux #(.N_CH(N_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .sync     (sync),
        .enable   (enable),
        .out      (out),
        .valid    (valid),
        .locked   (locked),
        .sync_err (sync_err),
        .slot     (slot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = -1;
    int valid_gap = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    // reference model: the frame in progress is just a queue of received bits
    bit              m_locked;
    bit              m_frame[$];
    logic [N_CH-1:0] m_out;
    bit              m_valid;
    bit              m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit s, input bit d);
        m_valid = 0;
        m_err   = 0;
        if (r) begin
            m_locked = 0;
            m_frame.delete();
            m_out = '0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1;
                    m_frame = {d};
                end
            end else if (s && m_frame.size() != 0) begin
                m_err = 1;
                m_frame = {d};
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == N_CH) begin
                    for (int k = 0; k < N_CH; k++) m_out[k] = m_frame[k];
                    m_valid = 1;
                    m_frame.delete();
                end
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input bit d, input bit r = 0);
        enable = e;
        sync   = s;
        in     = d;
        rst    = r;
        @(posedge clk);
        model_update(r, e, s, d);
        cyc++;
        #1;
        chk("valid", valid, m_valid);
        chk("sync_err", sync_err, m_err);
        chk("locked", locked, m_locked);
        chk("slot", slot, m_frame.size());
        chk("out", out, m_out);
        if (valid) begin
            valid_cnt++;
            if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (sync_err) err_cnt++;
    endtask

    task automatic send_frame(input logic [N_CH-1:0] f, input bit with_sync, input bit gaps);
        for (int k = 0; k < N_CH; k++) begin
            step(1, (k == 0) && with_sync, f[k]);
            if (gaps) step(0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    initial begin
        int v0;
        logic [SW-1:0] held;
        m_locked = 0;
        m_out = '0;

        // reset state
        step(0, 0, 0, 1);
        chk("rst_out", out, 0);
        chk("rst_locked", locked, 0);
        chk("rst_slot", slot, 0);

        // single synced frame 1,0,1,1
        step(1, 1, 1);
        chk("lock_after_first", locked, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        v0 = valid_cnt;
        step(1, 0, 1);
        chk("f1_valid", valid, 1);
        chk("f1_out", out, 4'b1101);
        chk("f1_slot", slot, 0);
        step(0, 0, 0);
        chk("f1_pulse_count", valid_cnt - v0, 1);

        // no sync after reset
        step(0, 0, 0, 1);
        v0 = valid_cnt;
        for (int i = 0; i < 8; i++) step(1, 0, $urandom_range(0, 1));
        chk("nosync_locked", locked, 0);
        chk("nosync_valid_cnt", valid_cnt - v0, 0);
        chk("nosync_out", out, 0);

        // gapped frame 0,1,1,0
        step(1, 1, 0);
        held = slot;
        step(0, 0, 1);
        chk("gap_slot_hold", slot, held);
        step(1, 0, 1); step(0, 1, 0);
        step(1, 0, 1); step(0, 0, 1);
        step(1, 0, 0);
        chk("gap_out", out, 4'b0110);

        // misaligned sync at slot 2
        step(1, 1, 0);
        step(1, 0, 0);
        chk("mis_pre_slot", slot, 2);
        v0 = valid_cnt;
        step(1, 1, 1);
        chk("mis_err", sync_err, 1);
        chk("mis_no_valid", valid, 0);
        chk("mis_slot", slot, 1);
        step(1, 0, 0);
        chk("mis_err_pulse", sync_err, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        chk("mis_out", out, 4'b1001);
        chk("mis_valid_cnt", valid_cnt - v0, 1);

        // reset mid-frame
        step(1, 1, 1);
        step(1, 0, 1);
        step(1, 0, 0, 1);
        chk("mrst_out", out, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_slot", slot, 0);
        send_frame(4'b1111, 1, 0);
        chk("mrst_out2", out, 4'b1111);

        // back-to-back frames A then 5
        v0 = err_cnt;
        send_frame(4'hA, 1, 0);
        chk("b2b_out_a", out, 4'hA);
        send_frame(4'h5, 1, 0);
        chk("b2b_out_5", out, 4'h5);
        chk("b2b_gap", valid_gap, N_CH);
        chk("b2b_no_err", err_cnt - v0, 0);

        // random soak against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1),
                 $urandom_range(0, 199) == 0);
            chk("excl_valid_err", valid & sync_err, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
